coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
- Front-end stage that sits directly upstream of the cola vending FSM and produces its 2-bit COIN code (01 = Rs5, 10 = Rs10, 00 = none).
- Debounces the two raw mechanical coin-sensor lines and rejects coins that trigger both sensors.
- Detects jammed sensors.
- Emits exactly one single-cycle COIN code per physical coin, holding it back while the vending FSM is dispensing.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive sampled-high cycles required to accept a coin; legal range 2 to MAX_PULSE-1.
- MAX_PULSE, 64: consecutive cycles of any sensor high, counted from leaving IDLE, that declare a jam.
- CNT_W, 8: width of the internal cycle counter; MAX_PULSE < 2**CNT_W.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- sense5, input, 1: raw Rs5 slot sensor, already synchronised to clk; high while a coin is present.
- sense10, input, 1: raw Rs10 slot sensor, same conditions as sense5.
- busy, input, 1: downstream dispensing indication, driven as OPEN | CHANGE of the vending FSM.
- COIN, output, 2: registered coin code to the vending FSM; non-zero for exactly one cycle per accepted coin.
- reject, output, 1: registered; one-cycle pulse requesting return of an invalid coin.
- jam, output, 1: registered, sticky fault flag; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; pending = 0; cnt = 0; COIN = 00; reject = 0; jam = 0.
  - Reset mid-qualification, or while a coin is pending, discards that coin; no COIN is emitted.
  - A sensor still high after reset starts a fresh qualification.
- States: IDLE, QUALIFY, WAIT_RELEASE, JAM.
- IDLE:
  - Sensors are ignored while pending = 1.
  - Otherwise, exactly one sensor sampled high -> QUALIFY; latch type (01 for sense5, 10 for sense10); cnt = 1.
  - Both sensors high -> reject pulse, cnt = 1, WAIT_RELEASE.
  - Neither sensor high -> stay in IDLE.
- QUALIFY:
  - Latched sensor high and the other low -> cnt + 1.
  - When cnt reaches DEBOUNCE_CYCLES: pending = 1, ptype = type, go to WAIT_RELEASE.
  - Latched sensor drops -> glitch; return to IDLE silently with cnt = 0; no output.
  - Other sensor rises (both high) -> reject pulse, WAIT_RELEASE; the coin is not accepted.
- WAIT_RELEASE:
  - cnt increments, saturating, while any sensor is high.
  - Both sensors low -> IDLE with cnt = 0.
- JAM entry: from QUALIFY or WAIT_RELEASE, when cnt reaches MAX_PULSE -> JAM.
- JAM: jam = 1; sensors ignored; no reject. Leaves only on reset.
- Output stage, evaluated every edge and independent of the state machine, including in JAM:
  - If pending = 1 and busy = 0: COIN <= ptype, pending <= 0.
  - Otherwise COIN <= 00.
  - While busy = 1, pending holds indefinitely.
- Latency: first sensor-high sample at edge E with busy low -> pending set at edge E+DEBOUNCE_CYCLES-1 -> COIN valid in the cycle after edge E+DEBOUNCE_CYCLES.
- reject is high for the single cycle after the edge at which both sensors were sampled high; otherwise 0.
- Only one coin can be in flight.
  - DEBOUNCE_CYCLES >= 2 plus the required release guarantees two COIN pulses are never adjacent cycles.
  - Therefore COIN is never presented in the cycle the vending FSM enters S15/S20 because of the previous coin.
- Simultaneous events:
  - Qualification completion and jam threshold on the same edge: jam wins; pending is still set and drains.
  - busy rising on the same edge pending is set: the coin is held.

Test Plan:
1. DEBOUNCE_CYCLES=4; sense5 high from edge 1 for 10 cycles, busy=0 -> COIN=01 only in the cycle after edge 5, then 00; reject=0; jam=0.
2. sense10 high for 2 cycles, then low (glitch) -> COIN stays 00, state back to IDLE, no reject.
3. sense5 and sense10 both rise on the same edge -> reject=1 for exactly one cycle, COIN stays 00; after both drop, a clean sense10 coin yields COIN=10 once.
4. sense10 qualified while busy=1 for 5 cycles -> COIN=00 throughout busy; COIN=10 in the cycle after the first edge with busy=0; exactly one pulse.
5. MAX_PULSE=64; sense5 held high for 100 cycles -> COIN=01 once (after edge 5), jam=1 from the cycle after edge 64 and remains 1 after sense5 drops; later coins are ignored; reset clears jam.
6. Reset asserted at edge 6 while pending=1 and busy=1 -> no COIN after reset; all outputs 0; sensor still high then requalifies and yields COIN=01 DEBOUNCE_CYCLES+1 edges after reset deasserts.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// Coin acceptor sensor/busy inputs and coin/fault outputs.
// slave is the acceptor side, master drives sensors and busy.
interface coin_acceptor_if;
   logic       sense5;
   logic       sense10;
   logic       busy;
   logic [1:0] COIN;
   logic       reject;
   logic       jam;

   modport master (
      output sense5,
      output sense10,
      output busy,
      input  COIN,
      input  reject,
      input  jam
   );

   modport slave (
      input  sense5,
      input  sense10,
      input  busy,
      output COIN,
      output reject,
      output jam
   );
endinterface

// File: rtl/coin_acceptor.sv
// Coin sensor front end: debounce, double-coin reject, jam detect,
// and a one-deep coin buffer that is held off while dispensing.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_PULSE       = 64,
   parameter int CNT_W           = 8
) (
   input  logic           clk,
   input  logic           reset,
   coin_acceptor_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      QUALIFY,
      WAIT_RELEASE,
      JAM
   } state_t;

   localparam logic [CNT_W-1:0] DEB  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PULSE);
   localparam logic [CNT_W-1:0] SAT  = '1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       ctype;
   logic [1:0]       ptype;
   logic             pending;
   logic [1:0]       coin_q;
   logic             reject_q;
   logic             jam_q;

   logic             s5;
   logic             s10;
   logic             any_hi;
   logic             both_hi;
   logic             one_hi;
   logic             lat_hi;
   logic [CNT_W-1:0] cnt_inc;
   logic             qual_done;
   logic             jam_hit;

   always_comb begin
      s5        = bus.sense5;
      s10       = bus.sense10;
      any_hi    = s5 | s10;
      both_hi   = s5 & s10;
      one_hi    = s5 ^ s10;
      lat_hi    = ctype[0] ? s5 : s10;
      cnt_inc   = (cnt == SAT) ? cnt : cnt + CNT_W'(1);
      qual_done = (cnt_inc == DEB);
      jam_hit   = (cnt_inc >= MAXP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         ctype    <= 2'b00;
         ptype    <= 2'b00;
         pending  <= 1'b0;
         coin_q   <= 2'b00;
         reject_q <= 1'b0;
         jam_q    <= 1'b0;
      end else begin
         reject_q <= 1'b0;

         // Drain runs in every state, JAM included.
         if (pending && !bus.busy) begin
            coin_q  <= ptype;
            pending <= 1'b0;
         end else begin
            coin_q <= 2'b00;
         end

         unique case (state)
            IDLE: begin
               if (!pending) begin
                  unique case (1'b1)
                     both_hi: begin
                        reject_q <= 1'b1;
                        cnt      <= CNT_W'(1);
                        state    <= WAIT_RELEASE;
                     end
                     one_hi: begin
                        ctype <= {s10, s5};
                        cnt   <= CNT_W'(1);
                        state <= QUALIFY;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end

            QUALIFY: begin
               unique case (1'b1)
                  !lat_hi: begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
                  both_hi: begin
                     reject_q <= 1'b1;
                     cnt      <= cnt_inc;
                     state    <= WAIT_RELEASE;
                     if (jam_hit) begin
                        state <= JAM;
                        jam_q <= 1'b1;
                     end
                  end
                  default: begin
                     cnt <= cnt_inc;
                     if (qual_done) begin
                        pending <= 1'b1;
                        ptype   <= ctype;
                        state   <= WAIT_RELEASE;
                     end
                     // Jam overrides the state move but the coin stays pending.
                     if (jam_hit) begin
                        state <= JAM;
                        jam_q <= 1'b1;
                     end
                  end
               endcase
            end

            WAIT_RELEASE: begin
               if (!any_hi) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt_inc;
                  if (jam_hit) begin
                     state <= JAM;
                     jam_q <= 1'b1;
                  end
               end
            end

            JAM: begin
               jam_q <= 1'b1;
               state <= JAM;
            end
         endcase
      end
   end

   assign bus.COIN   = coin_q;
   assign bus.reject = reject_q;
   assign bus.jam    = jam_q;

endmodule
